// File: rtl/rsa_keygen_seq.sv
// RSA exponent/inverse search: phi = (p-1)(q-1), first e = e_init + k*e_step coprime to phi, d = e^-1 mod phi.
// Optional `RSA_KEYGEN_CYCLES_EN adds the cycles/tries observation ports.
module rsa_keygen_seq #(
    parameter int WIDTH     = 32,
    parameter int MAX_TRIES = 64,
    parameter int TRY_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    input  logic [2*WIDTH-1:0]   e_init,
    input  logic [2*WIDTH-1:0]   e_step,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [2*WIDTH-1:0]   e,
    output logic [2*WIDTH-1:0]   d,
    output logic [2*WIDTH-1:0]   phi
`ifdef RSA_KEYGEN_CYCLES_EN
    ,
    output logic [31:0]          cycles,
    output logic [TRY_W-1:0]     tries
`endif
);

    localparam int XW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(XW);
    localparam logic [CNT_W-1:0]     DIV_LAST = CNT_W'(XW - 1);
    localparam logic signed [XW:0]   Y_ONE    = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV, S_UPDATE, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic                    armed;
    logic                    accept;
    logic [WIDTH-1:0]        p_r, q_r;
    logic [XW-1:0]           e_step_r;
    logic [XW-1:0]           a, b, rem, quo;
    logic signed [XW:0]      y, y_prev;
    logic [CNT_W-1:0]        div_cnt;
    logic [TRY_W-1:0]        try_cnt;
    logic [XW:0]             e_sum;
    logic [XW:0]             div_shift, div_sub;
    logic [XW-1:0]           pm1_x, qm1_x;
    logic                    bad_load, try_last;

    // Map a Bezout coefficient in (-phi, phi) onto [0, phi).
    function automatic logic [XW-1:0] fix_coef(input logic signed [XW:0] v,
                                               input logic [XW-1:0] m);
        logic signed [XW:0] s;
        s = v[XW] ? (v + $signed({1'b0, m})) : v;
        return s[XW-1:0];
    endfunction

    assign pm1_x     = {{WIDTH{1'b0}}, p - WIDTH'(1)};
    assign qm1_x     = {{WIDTH{1'b0}}, q - WIDTH'(1)};
    assign e_sum     = {1'b0, e} + {1'b0, e_step_r};
    assign div_shift = {rem, quo[XW-1]};
    assign div_sub   = div_shift - {1'b0, b};
    assign bad_load  = (p_r < WIDTH'(2)) || (q_r < WIDTH'(2)) ||
                       (phi <= XW'(1)) || (e >= phi);
    // A carry out of e + e_step ends the search the same way as the try limit.
    assign try_last  = ((try_cnt + TRY_W'(1)) == TRY_W'(MAX_TRIES)) ||
                       (e_step_r == '0) || e_sum[XW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = bad_load ? S_FAIL : S_DIV;
            S_DIV:    if (div_cnt == DIV_LAST) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = (rem == '0) ? S_CHECK : S_DIV;
            S_CHECK: begin
                if (a == XW'(1))  state_nxt = S_DONE;
                else if (try_last) state_nxt = S_FAIL;
                else               state_nxt = S_LOAD;
            end
            S_DONE:   state_nxt = S_IDLE;
            S_FAIL:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The first edge after reset release is never an accept edge.
    always_comb begin
        busy   = (state != S_IDLE);
        accept = start && armed && (state == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            e       <= '0;
            d       <= '0;
            phi     <= '0;
            try_cnt <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                done    <= 1'b0;
                fail    <= 1'b0;
                e       <= e_init;
                phi     <= pm1_x * qm1_x;
                try_cnt <= '0;
            end
            case (state)
                S_CHECK: begin
                    if (a != XW'(1)) begin
                        try_cnt <= try_cnt + TRY_W'(1);
                        if (!try_last) e <= e_sum[XW-1:0];
                    end
                end
                S_DONE: begin
                    d    <= fix_coef(y_prev, phi);
                    done <= 1'b1;
                end
                S_FAIL:  fail <= 1'b1;
                default: ;
            endcase
        end
    end

    // Euclid datapath: a/b restoring divide, then y tracks the coefficient of e in b.
    always_ff @(posedge clk) begin
        if (accept) begin
            p_r      <= p;
            q_r      <= q;
            e_step_r <= e_step;
        end
        case (state)
            S_LOAD: begin
                a       <= phi;
                b       <= e;
                y_prev  <= '0;
                y       <= Y_ONE;
                rem     <= '0;
                quo     <= phi;
                div_cnt <= '0;
            end
            S_DIV: begin
                if (!div_sub[XW]) begin
                    rem <= div_sub[XW-1:0];
                    quo <= {quo[XW-2:0], 1'b1};
                end else begin
                    rem <= div_shift[XW-1:0];
                    quo <= {quo[XW-2:0], 1'b0};
                end
                div_cnt <= div_cnt + CNT_W'(1);
            end
            S_UPDATE: begin
                a       <= b;
                b       <= rem;
                y       <= y_prev - $signed({1'b0, quo}) * y;
                y_prev  <= y;
                rem     <= '0;
                quo     <= b;
                div_cnt <= '0;
            end
            default: ;
        endcase
    end

`ifdef RSA_KEYGEN_CYCLES_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    cycles <= '0;
        else if (accept) cycles <= '0;
        else if (busy)   cycles <= sat_inc(cycles);
    end

    assign tries = try_cnt;
`endif

endmodule

// File: tb/tb_rsa_keygen_seq.sv
// Randomized and directed bench for rsa_keygen_seq against a gcd-based reference model.
module tb_rsa_keygen_seq;

    localparam int W     = 32;
    localparam int XW    = 64;
    localparam int MT    = 4;
    localparam int TW    = 3;
    localparam int LIMIT = 20000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [W-1:0]    p, q;
    logic [XW-1:0]   e_init, e_step;
    logic            busy, done, fail;
    logic [XW-1:0]   e, d, phi;
`ifdef RSA_KEYGEN_CYCLES_EN
    logic [31:0]     cycles;
    logic [TW-1:0]   tries;
`endif

    int n_total = 0;
    int n_bad   = 0;
    bit abort   = 1'b0;

    always #5 clk = ~clk;

    rsa_keygen_seq #(.WIDTH(W), .MAX_TRIES(MT), .TRY_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .p(p), .q(q), .e_init(e_init), .e_step(e_step),
        .busy(busy), .done(done), .fail(fail),
        .e(e), .d(d), .phi(phi)
`ifdef RSA_KEYGEN_CYCLES_EN
        , .cycles(cycles), .tries(tries)
`endif
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain gcd search over the candidate sequence, with its cycle cost.
    task automatic model(input logic [W-1:0] mp, input logic [W-1:0] mq,
                         input logic [XW-1:0] mei, input logic [XW-1:0] mes,
                         output bit m_done, output logic [XW-1:0] m_phi,
                         output logic [XW-1:0] m_e, output int m_cyc, output int m_tries);
        logic [XW-1:0] ph, ee, ga, gb, gr;
        logic [XW:0]   sum;
        int            steps;
        ph = {32'd0, mp - 32'd1} * {32'd0, mq - 32'd1};
        ee = mei;
        m_done = 1'b0; m_cyc = 0; m_tries = 0; m_phi = ph;
        while (1) begin
            m_cyc += 1;
            if (mp < 2 || mq < 2 || ph <= 1 || ee >= ph) begin m_cyc += 1; break; end
            ga = ph; gb = ee; steps = 0;
            while (gb != 0) begin gr = ga % gb; ga = gb; gb = gr; steps++; end
            m_cyc += steps * (2 * W + 1) + 1;
            if (ga == 1) begin m_cyc += 1; m_done = 1'b1; break; end
            m_tries++;
            sum = {1'b0, ee} + {1'b0, mes};
            if (m_tries == MT || mes == 0 || sum[XW]) begin m_cyc += 1; break; end
            ee = sum[XW-1:0];
        end
        m_e = ee;
    endtask

    task automatic wait_end(input string tag, output int waited);
        waited = 0;
        while (!(done || fail) && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (!(done || fail)) begin
            check_val({tag, ".timeout"}, {127'd0, done | fail}, 128'd1);
            abort = 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] cp, input logic [W-1:0] cq,
                               input logic [XW-1:0] cei, input logic [XW-1:0] ces);
        @(negedge clk);
        p = cp; q = cq; e_init = cei; e_step = ces; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] cp, input logic [W-1:0] cq,
                            input logic [XW-1:0] cei, input logic [XW-1:0] ces);
        bit            m_done;
        logic [XW-1:0] m_phi, m_e;
        int            m_cyc, m_tr, waited;
        logic [127:0]  prod;
        if (abort) return;
        model(cp, cq, cei, ces, m_done, m_phi, m_e, m_cyc, m_tr);
        pulse_start(cp, cq, cei, ces);
        check_val({tag, ".busy1"}, busy, 1);
        check_val({tag, ".cleared"}, {done, fail}, 0);
        wait_end(tag, waited);
        if (abort) return;
        check_val({tag, ".lat"}, waited, m_cyc);
        check_val({tag, ".done"}, done, m_done);
        check_val({tag, ".fail"}, fail, !m_done);
        check_val({tag, ".busy0"}, busy, 0);
        check_val({tag, ".phi"}, phi, m_phi);
        if (m_done) begin
            check_val({tag, ".e"}, e, m_e);
            check_val({tag, ".drange"}, (d >= 1 && d < phi), 1);
            prod = {64'd0, e} * {64'd0, d};
            check_val({tag, ".inv"}, prod % {64'd0, phi}, 1);
        end
`ifdef RSA_KEYGEN_CYCLES_EN
        check_val({tag, ".cycles"}, cycles, m_cyc);
        check_val({tag, ".tries"}, tries, m_tr);
`endif
    endtask

    initial begin
        int waited;
        logic [W-1:0]  rp, rq;
        logic [XW-1:0] rei, res;
        reset_n = 1'b0; start = 1'b0;
        p = '0; q = '0; e_init = '0; e_step = '0;
        @(posedge clk); #1;
        check_val("rst.busy", busy, 0);
        check_val("rst.done", done, 0);
        check_val("rst.fail", fail, 0);
        check_val("rst.e", e, 0);
        check_val("rst.d", d, 0);
        check_val("rst.phi", phi, 0);
        repeat (2) @(negedge clk);

        // start held high across reset release must not be accepted
        p = 61; q = 53; e_init = 17; e_step = 2; start = 1'b1; reset_n = 1'b1;
        @(posedge clk); #1;
        check_val("rel.busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check_val("rel.busy2", busy, 0);

        run_case("tp1", 61, 53, 17, 2);
        check_val("tp1.d", d, 2753);
        check_val("tp1.phi_k", phi, 3120);
        run_case("tp2", 61, 53, 3, 2);
        check_val("tp2.e", e, 7);
        check_val("tp2.d", d, 1783);
        run_case("tp3", 11, 13, 7, 2);
        check_val("tp3.d", d, 103);
        run_case("tp4", 3, 5, 2, 2);
        check_val("tp4.fail", {done, fail}, 2'b01);
        run_case("p1", 1, 53, 17, 2);
        check_val("p1.fail", fail, 1);
        run_case("trylim", 61, 53, 2, 2);
        run_case("step0", 61, 53, 4, 0);
        run_case("ovf", 32'hFFFF_FFFB, 32'hFFFF_FFFB, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_case("big", 32'hFFFF_FFFB, 32'hFFFF_FFEF, 65537, 2);

        // start while busy is ignored
        if (!abort) begin
            pulse_start(61, 53, 17, 2);
            repeat (40) @(negedge clk);
            p = 11; q = 13; e_init = 7; e_step = 2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_val("ign.busy", busy, 1);
            wait_end("ign", waited);
            check_val("ign.e", e, 17);
            check_val("ign.d", d, 2753);
            check_val("ign.phi", phi, 3120);
        end

        // asynchronous abort mid-search, then a clean rerun
        if (!abort) begin
            pulse_start(61, 53, 17, 2);
            repeat (100) @(negedge clk);
            #2 reset_n = 1'b0;
            #1;
            check_val("mid.busy", busy, 0);
            check_val("mid.done", done, 0);
            check_val("mid.fail", fail, 0);
            check_val("mid.e", e, 0);
            check_val("mid.d", d, 0);
            check_val("mid.phi", phi, 0);
            @(negedge clk);
            reset_n = 1'b1;
            repeat (2) @(negedge clk);
            run_case("fresh", 61, 53, 17, 2);
            check_val("fresh.d", d, 2753);
        end

        for (int i = 0; i < 10; i++) begin
            rp  = $urandom_range(0, 4095);
            rq  = $urandom_range(2, 4095);
            rei = 64'($urandom_range(1, 5000));
            res = 64'($urandom_range(0, 6));
            run_case($sformatf("rnd%0d", i), rp, rq, rei, res);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
